// File: rtl/int_ctrl_pkg.sv
// Shared types and constants for the platform interrupt controller:
// code width, register map selectors and FSM state encodings.
package int_ctrl_pkg;

  localparam int INT_CODE_WIDTH = 5;
  localparam int BUS_AW         = 5;
  localparam int BUS_DW         = 32;

  typedef logic [INT_CODE_WIDTH-1:0] code_t;

  localparam code_t CODE_NONE = '0;

  // Register selector is the word index bus_addr[4:2].
  typedef enum logic [2:0] {
    REG_PENDING = 3'd0,
    REG_ENABLE  = 3'd1,
    REG_TRIGGER = 3'd2,
    REG_CLAIM   = 3'd3,
    REG_SOFT    = 3'd4
  } reg_sel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/int_ctrl_if.sv
// Peripheral-bus register window of the interrupt controller.
interface int_ctrl_if;
  import int_ctrl_pkg::*;

  logic [BUS_AW-1:0] bus_addr;
  logic [BUS_DW-1:0] bus_wdata;
  logic              bus_wen;
  logic              bus_ren;
  logic [BUS_DW-1:0] bus_rdata;

  modport master (
    output bus_addr, bus_wdata, bus_wen, bus_ren,
    input  bus_rdata
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_wen, bus_ren,
    output bus_rdata
  );

endinterface

// File: rtl/int_prio_enc.sv
// Combinational priority encoder: lowest set request bit wins and is
// reported as index+1, with a valid flag when any bit is set.
module int_prio_enc #(
  parameter int NUM_SRC = 16,
  parameter int CODE_W  = 5
) (
  input  logic [NUM_SRC-1:0] req_i,
  output logic [CODE_W-1:0]  code_o,
  output logic               valid_o
);

  always_comb begin
    // NOTE: default assignment first so every path drives code_o (no latch).
    code_o = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) code_o = CODE_W'(i + 1);
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller top: per-source edge/level gateway, pending/enable/
// trigger registers, claim/complete FSM, SOFT register and bus decode.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_irq,
  int_ctrl_if.slave          bus,
  output code_t              peripheral_int_code,
  output code_t              soft_int_code
);

  state_e              state_q, state_d;
  logic [NUM_SRC-1:0]  pending_q, pending_d;
  logic [NUM_SRC-1:0]  enable_q, enable_d;
  logic [NUM_SRC-1:0]  trigger_q, trigger_d;
  logic [NUM_SRC-1:0]  prev_q;
  code_t               active_q, active_d;
  code_t               soft_q, soft_d;
  code_t               code_q, code_d;
  logic [BUS_DW-1:0]   rdata_q, rdata_d;

  code_t               win_code;
  logic                win_valid;
  logic [2:0]          sel;
  logic                claim_take, complete;
  logic [NUM_SRC-1:0]  claim_clr, in_service, set_req;

  assign sel        = bus.bus_addr[4:2];
  assign claim_take = bus.bus_ren && (sel == REG_CLAIM) && (state_q == ST_IDLE) && win_valid;
  assign complete   = bus.bus_wen && (sel == REG_CLAIM) && (state_q == ST_BUSY)
                      && (bus.bus_wdata[INT_CODE_WIDTH-1:0] == active_q);

  int_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .CODE_W  (INT_CODE_WIDTH)
  ) u_prio_enc (
    .req_i   (pending_q & enable_q),
    .code_o  (win_code),
    .valid_o (win_valid)
  );

  // A source being claimed this cycle already counts as in service, so a
  // held level line does not re-pend until its completion.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      claim_clr[i]  = claim_take && (win_code == code_t'(i + 1));
      in_service[i] = claim_clr[i] || ((state_q == ST_BUSY) && (active_q == code_t'(i + 1)));
    end
    set_req   = (trigger_q & src_irq & ~prev_q) | (~trigger_q & src_irq & ~in_service);
    pending_d = (pending_q & ~claim_clr) | set_req;
  end

  always_comb begin
    enable_d  = enable_q;
    trigger_d = trigger_q;
    soft_d    = soft_q;
    active_d  = claim_take ? win_code : active_q;
    if (bus.bus_wen) begin
      case (sel)
        REG_ENABLE:  enable_d  = bus.bus_wdata[NUM_SRC-1:0];
        REG_TRIGGER: trigger_d = bus.bus_wdata[NUM_SRC-1:0];
        REG_SOFT:    soft_d    = bus.bus_wdata[INT_CODE_WIDTH-1:0];
        default: ;
      endcase
    end
    rdata_d = rdata_q;
    if (bus.bus_ren) begin
      case (sel)
        REG_PENDING: rdata_d = BUS_DW'(pending_q);
        REG_ENABLE:  rdata_d = BUS_DW'(enable_q);
        REG_TRIGGER: rdata_d = BUS_DW'(trigger_q);
        REG_CLAIM:   rdata_d = BUS_DW'(claim_take ? win_code : CODE_NONE);
        REG_SOFT:    rdata_d = BUS_DW'(soft_q);
        default:     rdata_d = '0;
      endcase
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (claim_take) state_d = ST_BUSY;
      ST_BUSY: if (complete)   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: output; keyed on the next state so a claim silences the code at once.
  always_comb begin
    code_d = CODE_NONE;
    if ((state_d == ST_IDLE) && win_valid) code_d = win_code;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      enable_q  <= '0;
      trigger_q <= '0;
      prev_q    <= '0;
      active_q  <= CODE_NONE;
      soft_q    <= CODE_NONE;
      code_q    <= CODE_NONE;
      rdata_q   <= '0;
    end else begin
      pending_q <= pending_d;
      enable_q  <= enable_d;
      trigger_q <= trigger_d;
      prev_q    <= src_irq;
      active_q  <= active_d;
      soft_q    <= soft_d;
      code_q    <= code_d;
      rdata_q   <= rdata_d;
    end
  end

  assign peripheral_int_code = code_q;
  assign soft_int_code       = soft_q;
  assign bus.bus_rdata       = rdata_q;

  logic unused_addr;
  assign unused_addr = ^bus.bus_addr[1:0];

  if (NUM_SRC < BUS_DW) begin : g_unused_wdata
    logic unused_wdata;
    assign unused_wdata = ^bus.bus_wdata[BUS_DW-1:NUM_SRC];
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: bus reads are scored through a queue of
// expected read data; code outputs are compared against hand-derived values.
module tb_int_ctrl;
  import int_ctrl_pkg::*;

  localparam int NUM_SRC = 16;
  localparam logic [4:0] A_PEND  = 5'h00;
  localparam logic [4:0] A_EN    = 5'h04;
  localparam logic [4:0] A_TRIG  = 5'h08;
  localparam logic [4:0] A_CLAIM = 5'h0C;
  localparam logic [4:0] A_SOFT  = 5'h10;
  localparam logic [4:0] A_RSVD  = 5'h14;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_SRC-1:0] src_irq;
  code_t              peripheral_int_code;
  code_t              soft_int_code;

  int_ctrl_if bus_if ();

  int_ctrl #(.NUM_SRC(NUM_SRC)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .src_irq             (src_irq),
    .bus                 (bus_if),
    .peripheral_int_code (peripheral_int_code),
    .soft_int_code       (soft_int_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } rd_exp_t;

  rd_exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    bus_if.bus_addr  = a;
    bus_if.bus_wdata = d;
    bus_if.bus_wen   = 1'b1;
    tick();
    bus_if.bus_wen   = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, input logic [31:0] exp, input string tag);
    rd_exp_t e;
    sb.push_back('{tag: tag, exp: exp});
    bus_if.bus_addr = a;
    bus_if.bus_ren  = 1'b1;
    tick();
    bus_if.bus_ren  = 1'b0;
    e = sb.pop_front();
    check(e.tag, bus_if.bus_rdata, e.exp);
  endtask

  task automatic bus_rw(input logic [4:0] a, input logic [31:0] d, input logic [31:0] exp,
                        input string tag);
    rd_exp_t e;
    sb.push_back('{tag: tag, exp: exp});
    bus_if.bus_addr  = a;
    bus_if.bus_wdata = d;
    bus_if.bus_wen   = 1'b1;
    bus_if.bus_ren   = 1'b1;
    tick();
    bus_if.bus_wen   = 1'b0;
    bus_if.bus_ren   = 1'b0;
    e = sb.pop_front();
    check(e.tag, bus_if.bus_rdata, e.exp);
  endtask

  task automatic pulse(input logic [NUM_SRC-1:0] m);
    src_irq = m;
    tick();
    src_irq = '0;
  endtask

  task automatic wait_code(input code_t exp, input int max_cyc, input string tag);
    int n = 0;
    while (peripheral_int_code !== exp && n < max_cyc) begin
      tick();
      n++;
    end
    check(tag, 32'(peripheral_int_code), 32'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, observed timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst              = 1'b1;
    src_irq          = '0;
    bus_if.bus_addr  = '0;
    bus_if.bus_wdata = '0;
    bus_if.bus_wen   = 1'b0;
    bus_if.bus_ren   = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_code", 32'(peripheral_int_code), 32'd0);
    check("rst_soft", 32'(soft_int_code), 32'd0);
    check("rst_rdata", bus_if.bus_rdata, 32'd0);
    bus_read(A_PEND, 32'h0, "rst_pending");
    bus_read(A_EN,   32'h0, "rst_enable");
    bus_read(A_TRIG, 32'h0, "rst_trigger");

    // Level source 3
    bus_write(A_EN, 32'h8);
    src_irq[3] = 1'b1;
    tick();
    check("lvl_n1", 32'(peripheral_int_code), 32'd0);
    tick();
    check("lvl_n2", 32'(peripheral_int_code), 32'd4);
    bus_read(A_CLAIM, 32'd4, "lvl_claim");
    check("lvl_claim_drop", 32'(peripheral_int_code), 32'd0);
    bus_read(A_CLAIM, 32'd0, "lvl_busy_claim");
    bus_write(A_CLAIM, 32'd4);
    wait_code(5'd4, 4, "lvl_represent");
    bus_read(A_CLAIM, 32'd4, "lvl_reclaim");
    src_irq[3] = 1'b0;
    bus_write(A_CLAIM, 32'd4);
    tick();
    tick();
    check("lvl_quiet", 32'(peripheral_int_code), 32'd0);

    // Edge sources 2 and 5 together
    bus_write(A_EN, 32'hFFFF);
    bus_write(A_TRIG, 32'hFFFF);
    pulse(16'h0024);
    tick();
    check("edge_first", 32'(peripheral_int_code), 32'd3);
    bus_read(A_CLAIM, 32'd3, "edge_claim3");
    bus_read(A_PEND, 32'h20, "edge_pend_busy");
    check("edge_busy_code", 32'(peripheral_int_code), 32'd0);
    bus_write(A_CLAIM, 32'd3);
    wait_code(5'd6, 3, "edge_second");
    bus_read(A_CLAIM, 32'd6, "edge_claim6");
    bus_write(A_CLAIM, 32'd6);
    bus_read(A_PEND, 32'h0, "edge_pend_end");

    // Wrong completion code is ignored while BUSY
    pulse(16'h0004);
    wait_code(5'd3, 4, "wc_present");
    bus_read(A_CLAIM, 32'd3, "wc_claim");
    bus_write(A_CLAIM, 32'd7);
    check("wc_ignored", 32'(peripheral_int_code), 32'd0);
    pulse(16'h0002);
    tick();
    tick();
    check("wc_still_busy", 32'(peripheral_int_code), 32'd0);
    bus_read(A_CLAIM, 32'd0, "wc_busy_claim");
    bus_write(A_CLAIM, 32'd3);
    wait_code(5'd2, 3, "wc_idle");
    bus_read(A_CLAIM, 32'd2, "wc_claim2");
    bus_write(A_CLAIM, 32'd2);

    // Edge on source 0 in the same cycle as its claim
    pulse(16'h0001);
    wait_code(5'd1, 4, "sc_present");
    src_irq = 16'h0001;
    bus_read(A_CLAIM, 32'd1, "sc_claim");
    src_irq = '0;
    bus_read(A_PEND, 32'h1, "sc_pend_kept");
    bus_write(A_CLAIM, 32'd1);
    wait_code(5'd1, 3, "sc_represent");
    bus_read(A_CLAIM, 32'd1, "sc_reclaim");
    bus_write(A_CLAIM, 32'd1);
    bus_read(A_PEND, 32'h0, "sc_pend_end");

    // SOFT register independent of the external path
    bus_write(A_SOFT, 32'h5);
    check("soft_raise", 32'(soft_int_code), 32'd5);
    check("soft_no_ext", 32'(peripheral_int_code), 32'd0);
    bus_read(A_SOFT, 32'h5, "soft_read");
    pulse(16'h0100);
    wait_code(5'd9, 4, "soft_ext_present");
    bus_write(A_SOFT, 32'h0);
    check("soft_drop", 32'(soft_int_code), 32'd0);
    check("soft_ext_kept", 32'(peripheral_int_code), 32'd9);
    bus_read(A_CLAIM, 32'd9, "soft_claim9");
    bus_write(A_CLAIM, 32'd9);

    // Bus corner cases
    bus_rw(A_EN, 32'h00FF, 32'hFFFF, "rw_pre_value");
    bus_read(A_EN, 32'h00FF, "rw_post_value");
    bus_write(A_PEND, 32'hFFFF);
    bus_read(A_PEND, 32'h0, "pend_ro");
    bus_write(A_RSVD, 32'hDEAD);
    bus_read(A_RSVD, 32'h0, "rsvd_zero");
    pulse(16'h0800);
    bus_write(A_TRIG, 32'h0);
    bus_read(A_PEND, 32'h800, "trig_keeps_pend");
    bus_read(A_TRIG, 32'h0, "trig_written");

    // Reset while BUSY with pending bits set
    bus_write(A_EN, 32'hFFFF);
    bus_write(A_TRIG, 32'hFFFF);
    pulse(16'h0030);
    wait_code(5'd5, 4, "rb_present");
    bus_read(A_CLAIM, 32'd5, "rb_claim");
    bus_write(A_SOFT, 32'h3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rb_code", 32'(peripheral_int_code), 32'd0);
    check("rb_soft", 32'(soft_int_code), 32'd0);
    check("rb_rdata", bus_if.bus_rdata, 32'd0);
    bus_read(A_PEND,  32'h0, "rb_pending");
    bus_read(A_EN,    32'h0, "rb_enable");
    bus_read(A_TRIG,  32'h0, "rb_trigger");
    bus_read(A_SOFT,  32'h0, "rb_soft_reg");
    bus_read(A_CLAIM, 32'h0, "rb_claim_none");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
